lsu_store_buffer: RTL and testbench

//  Word-granular store buffer between LSU execute and the single-ported data RAM.

---
 rtl/lsu_store_buffer.sv | 87 ++++++++
 tb/tb_lsu_store_buffer.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/lsu_store_buffer.sv
// lsu_store_buffer: in-order word store buffer with load forwarding and single-port RAM arbitration
module lsu_store_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          stall,
  input  logic          ex_wr_en,
  input  logic [AW-1:0] ex_wr_addr,
  input  logic [DW-1:0] ex_wr_data,
  input  logic          ex_rd_en,
  input  logic [AW-1:0] ex_rd_addr,
  output logic [AW-1:0] ram_addr,
  output logic          ram_wr_en,
  output logic [DW-1:0] ram_wr_data,
  output logic          ram_rd_en,
  input  logic          ram_wr_rdy,
  input  logic [DW-1:0] ram_rd_data,
  output logic [DW-1:0] wb_rd_data,
  output logic          sb_stall,
  output logic          sb_empty
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  logic [AW-1:0] addr_q [DEPTH];
  logic [DW-1:0] data_q [DEPTH];
  logic [DEPTH-1:0] valid_q;
  logic [PW-1:0] head, tail, idx;
  logic [CW-1:0] count;
  logic fwd_hit_q, full, empty, push, load, hit, port_free, drain, byp;
  logic [DW-1:0] fwd_data_q, hit_data;
  assign full = count == CW'(DEPTH);
  assign empty = count == '0;
  assign push = ex_wr_en & !stall & !full;
  assign load = ex_rd_en & !stall;
  // Scan oldest to youngest so the youngest matching entry overrides.
  always_comb begin
    hit = 1'b0;
    hit_data = '0;
    idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + PW'(i);
      if (valid_q[idx] && addr_q[idx] == ex_rd_addr) begin
        hit = 1'b1;
        hit_data = data_q[idx];
      end
    end
  end
  assign port_free = !(load & !hit);
  assign ram_rd_en = load & !hit & !rst;
  assign drain = !empty & ram_wr_rdy & port_free & !rst;
  // An empty buffer lets a store go straight to RAM in its EX cycle.
  assign byp = push & empty & ram_wr_rdy & port_free & !rst;
  assign ram_wr_en = drain | byp;
  assign ram_addr = ram_rd_en ? ex_rd_addr : drain ? addr_q[head] : byp ? ex_wr_addr : '0;
  assign ram_wr_data = drain ? data_q[head] : byp ? ex_wr_data : '0;
  assign wb_rd_data = fwd_hit_q ? fwd_data_q : ram_rd_data;
  assign sb_stall = full;
  assign sb_empty = empty;
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
      head <= '0;
      tail <= '0;
      valid_q <= '0;
      fwd_hit_q <= 1'b0;
      fwd_data_q <= '0;
    end else begin
      fwd_hit_q <= load & hit;
      fwd_data_q <= hit_data;
      if (push && !byp) begin
        addr_q[tail] <= ex_wr_addr;
        data_q[tail] <= ex_wr_data;
        valid_q[tail] <= 1'b1;
        tail <= tail + 1'b1;
      end
      if (drain) begin
        valid_q[head] <= 1'b0;
        head <= head + 1'b1;
      end
      count <= count + CW'(push & !byp) - CW'(drain);
    end
  end
  assert property (@(posedge clk) disable iff (rst) !(ex_wr_en && ex_rd_en));
endmodule

// File: tb/tb_lsu_store_buffer.sv
// tb_lsu_store_buffer: scoreboard bench; expected RAM writes and load results are queued and checked by a monitor
module tb_lsu_store_buffer;
  logic clk = 0;
  logic rst = 1, stall = 0, ex_wr_en = 0, ex_rd_en = 0, ram_wr_rdy = 0;
  logic [31:0] ex_wr_addr = 0, ex_wr_data = 0, ex_rd_addr = 0, ram_rd_data = 0;
  logic [31:0] ram_addr, ram_wr_data, wb_rd_data;
  logic ram_wr_en, ram_rd_en, sb_stall, sb_empty;
  int checks = 0, fails = 0;
  typedef struct {logic [31:0] a; logic [31:0] d;} wr_t;
  wr_t wq[$];
  logic [31:0] lq[$];
  wr_t e;
  logic ld_q = 0;
  always #5 clk = ~clk;
  lsu_store_buffer #(.DEPTH(4), .AW(32), .DW(32)) dut (
    .clk(clk), .rst(rst), .stall(stall), .ex_wr_en(ex_wr_en), .ex_wr_addr(ex_wr_addr),
    .ex_wr_data(ex_wr_data), .ex_rd_en(ex_rd_en), .ex_rd_addr(ex_rd_addr), .ram_addr(ram_addr),
    .ram_wr_en(ram_wr_en), .ram_wr_data(ram_wr_data), .ram_rd_en(ram_rd_en), .ram_wr_rdy(ram_wr_rdy),
    .ram_rd_data(ram_rd_data), .wb_rd_data(wb_rd_data), .sb_stall(sb_stall), .sb_empty(sb_empty)
  );
  always @(posedge clk) ram_rd_data <= ram_rd_en ? (ram_addr ^ 32'hA5A5_0000) : 32'h0;
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (ram_wr_en) begin
      if (wq.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL unexpected_write: got addr %h data %h expected no write", ram_addr, ram_wr_data);
      end else begin
        e = wq.pop_front();
        chk("wr_addr", ram_addr, e.a);
        chk("wr_data", ram_wr_data, e.d);
      end
    end
    if (ld_q) begin
      if (lq.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL unexpected_load: got %h expected no load", wb_rd_data);
      end else chk("wb_rd_data", wb_rd_data, lq.pop_front());
    end
    ld_q <= ex_rd_en & !stall & !rst;
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic store(input logic [31:0] a, input logic [31:0] d, input bit expw);
    bit done = 0;
    ex_wr_en = 1;
    ex_wr_addr = a;
    ex_wr_data = d;
    if (expw) wq.push_back('{a, d});
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      done = !sb_stall && !stall;
      tick();
    end
    if (!done) begin
      checks++;
      fails++;
      $display("FAIL store_timeout: got no accept expected accept of %h", a);
    end
    ex_wr_en = 0;
  endtask
  task automatic wait_empty(input string n);
    bit done = 0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      done = sb_empty;
      if (!done) tick();
    end
    chk(n, {31'b0, done}, 32'd1);
    tick();
  endtask
  initial begin
    tick();
    tick();
    @(negedge clk);
    chk("rst_wr_en", ram_wr_en, 0);
    chk("rst_rd_en", ram_rd_en, 0);
    chk("rst_addr", ram_addr, 0);
    chk("rst_wdata", ram_wr_data, 0);
    chk("rst_stall", sb_stall, 0);
    chk("rst_empty", sb_empty, 1);
    chk("rst_wb", wb_rd_data, 0);
    tick();
    rst = 0;
    // 1: store into empty buffer writes RAM in the same cycle
    ram_wr_rdy = 1;
    ex_wr_en = 1; ex_wr_addr = 32'h100; ex_wr_data = 32'hDEAD_BEEF;
    wq.push_back('{32'h100, 32'hDEAD_BEEF});
    @(negedge clk);
    chk("t1_wr_en", ram_wr_en, 1);
    chk("t1_addr", ram_addr, 32'h100);
    tick();
    ex_wr_en = 0;
    @(negedge clk);
    chk("t1_empty", sb_empty, 1);
    tick();
    // 2: fill, stall on full, drain in order
    ram_wr_rdy = 0;
    for (int i = 0; i < 4; i++) store(32'h10 + 32'(4 * i), 32'h1000 + 32'(i), 1);
    @(negedge clk);
    chk("t2_full", sb_stall, 1);
    chk("t2_nempty", sb_empty, 0);
    ex_wr_en = 1; ex_wr_addr = 32'h20; ex_wr_data = 32'h1004;
    wq.push_back('{32'h20, 32'h1004});
    tick();
    ram_wr_rdy = 1;
    @(negedge clk);
    chk("t2_stall_drain", sb_stall, 1);
    tick();
    @(negedge clk);
    chk("t2_accept", sb_stall, 0);
    tick();
    ex_wr_en = 0;
    wait_empty("t2_empty");
    chk("t2_wq", wq.size(), 0);
    // 3: youngest forwarded
    ram_wr_rdy = 0;
    store(32'h40, 32'h11, 1);
    store(32'h40, 32'h22, 1);
    ex_rd_en = 1; ex_rd_addr = 32'h40;
    lq.push_back(32'h22);
    @(negedge clk);
    chk("t3_rd_en", ram_rd_en, 0);
    tick();
    ex_rd_en = 0;
    ram_wr_rdy = 1;
    wait_empty("t3_empty");
    // 4: load miss takes port, drain follows
    ram_wr_rdy = 0;
    store(32'h84, 32'h44, 1);
    ram_wr_rdy = 1;
    ex_rd_en = 1; ex_rd_addr = 32'h80;
    lq.push_back(32'h80 ^ 32'hA5A5_0000);
    @(negedge clk);
    chk("t4_rd_en", ram_rd_en, 1);
    chk("t4_no_wr", ram_wr_en, 0);
    chk("t4_addr", ram_addr, 32'h80);
    tick();
    ex_rd_en = 0;
    @(negedge clk);
    chk("t4_drain", ram_wr_en, 1);
    tick();
    @(negedge clk);
    chk("t4_empty", sb_empty, 1);
    tick();
    // 5: stalled store pushed exactly once
    ram_wr_rdy = 0;
    stall = 1;
    ex_wr_en = 1; ex_wr_addr = 32'h200; ex_wr_data = 32'h55;
    wq.push_back('{32'h200, 32'h55});
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t5_stalled", sb_empty, 1);
      tick();
    end
    stall = 0;
    tick();
    ex_wr_en = 0;
    @(negedge clk);
    chk("t5_one", sb_empty, 0);
    tick();
    ram_wr_rdy = 1;
    wait_empty("t5_empty");
    // 6: reset discards pending stores, then wrap twice
    ram_wr_rdy = 0;
    for (int i = 0; i < 3; i++) store(32'h300 + 32'(4 * i), 32'h77 + 32'(i), 0);
    rst = 1;
    ram_wr_rdy = 1;
    @(negedge clk);
    chk("t6_rst_nowr", ram_wr_en, 0);
    tick();
    rst = 0;
    @(negedge clk);
    chk("t6_empty", sb_empty, 1);
    chk("t6_nostall", sb_stall, 0);
    chk("t6_nowr", ram_wr_en, 0);
    tick();
    for (int r = 0; r < 2; r++) begin
      ram_wr_rdy = 0;
      for (int i = 0; i < 4; i++) store(32'h400 + 32'(16 * r + 4 * i), 32'h900 + 32'(8 * r + i), 1);
      @(negedge clk);
      chk("t6_full", sb_stall, 1);
      tick();
      ex_rd_en = 1; ex_rd_addr = 32'h400 + 32'(16 * r + 8);
      lq.push_back(32'h900 + 32'(8 * r + 2));
      tick();
      ex_rd_en = 0;
      ram_wr_rdy = 1;
      wait_empty("t6_wrap_empty");
    end
    chk("wq_left", wq.size(), 0);
    chk("lq_left", lq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
